// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg
//   Shared definitions for the two-master RAM port arbiter.
//   DPRAM_DW  - RAM data width
//   DPRAM_BW  - number of byte lanes (write mask width)
//   owner_t   - who is waiting for the read data returning this cycle
package dpram_arb_pkg;

    localparam int DPRAM_DW = 32;
    localparam int DPRAM_BW = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/dpram_arb_pick.sv
// dpram_arb_pick
//   Two-requester picker: grants the preferred requester when it asks,
//   otherwise the other one. Output is one-hot or zero.
//   req[1:0]  in   requests (bit 0 = m0, bit 1 = m1)
//   pref      in   preferred requester (0 = m0, 1 = m1)
//   gnt[1:0]  out  grant, one-hot or zero
module dpram_arb_pick (
    input  logic [1:0] req,
    input  logic       pref,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (pref == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/dpram_arb.sv
// dpram_arb
//   Arbitrates two masters (m0 = core LSU, m1 = debug/DMA) onto one port of
//   the byte-maskable dual-port RAM. One access per cycle; read data comes
//   back one cycle after the grant and is routed only to its owner.
//   Build option: define DPRAM_ARB_RR_EN for round-robin arbitration;
//   otherwise fixed priority m0 > m1 with an m1 starvation guard.
//   Ports:
//     clk, rst                      clock, async active-high reset
//     mN_req/we/wem/addr/wdata      master N request and fields (N = 0, 1)
//     mN_gnt                        access accepted this cycle (combinational)
//     mN_rvalid/mN_rdata            read response, rdata is 0 when not valid
//     ram_en/we/wem/addr/din        RAM port drive, all zero when idle
//     ram_dout                      RAM registered read data
module dpram_arb
    import dpram_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [DPRAM_BW-1:0] m0_wem,
    input  logic [AW-1:0]       m0_addr,
    input  logic [DPRAM_DW-1:0] m0_wdata,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DPRAM_DW-1:0] m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [DPRAM_BW-1:0] m1_wem,
    input  logic [AW-1:0]       m1_addr,
    input  logic [DPRAM_DW-1:0] m1_wdata,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DPRAM_DW-1:0] m1_rdata,

    output logic                ram_en,
    output logic                ram_we,
    output logic [DPRAM_BW-1:0] ram_wem,
    output logic [AW-1:0]       ram_addr,
    output logic [DPRAM_DW-1:0] ram_din,
    input  logic [DPRAM_DW-1:0] ram_dout
);

    logic [1:0] req;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       pref;
    owner_t     rd_owner;
    owner_t     rd_owner_nxt;

    assign req = {m1_req, m0_req};

    dpram_arb_pick u_pick (
        .req  (req),
        .pref (pref),
        .gnt  (pick_gnt)
    );

    // Grants are masked during reset so nothing reaches the RAM while the
    // arbiter state is being cleared.
    assign gnt    = rst ? 2'b00 : pick_gnt;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

`ifdef DPRAM_ARB_RR_EN
    // rr_ptr names the master preferred in the next arbitration; after any
    // grant it flips to the master that did not win.
    logic rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt[0]) begin
            rr_ptr <= 1'b1;
        end else if (gnt[1]) begin
            rr_ptr <= 1'b0;
        end
    end

    assign pref = rr_ptr;
`else
    // Starvation guard: m0 normally wins, but once m1 has been denied in
    // STARVE_MAX consecutive cycles it is preferred for one arbitration.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!m1_req || gnt[1]) begin
            starve_cnt <= 4'd0;
        end else if (gnt[0] && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign pref = (starve_cnt == STARVE_LIM);
`endif

    // Request mux: the winner's fields go to the RAM. Reads present a zero
    // byte mask so the RAM never sees a stray write lane.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt[0]) begin
            ram_en   = 1'b1;
            ram_we   = m0_we;
            ram_wem  = m0_we ? m0_wem : '0;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (gnt[1]) begin
            ram_en   = 1'b1;
            ram_we   = m1_we;
            ram_wem  = m1_we ? m1_wem : '0;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    // The owner tracks only the read granted in the previous cycle, which
    // is what lets a new access be granted while that data returns.
    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (gnt[0] && !m0_we) begin
            rd_owner_nxt = OWN_M0;
        end else if (gnt[1] && !m1_we) begin
            rd_owner_nxt = OWN_M1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    assign m0_rvalid = (rd_owner == OWN_M0);
    assign m1_rvalid = (rd_owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? ram_dout : '0;
    assign m1_rdata  = m1_rvalid ? ram_dout : '0;

endmodule
